sensor_event_monitor: RTL

//  Downstream consumer of the single-bit sensor detection level, one bit per

---
 rtl/sensor_event_monitor.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/sensor_event_monitor.sv
// sensor_event_monitor
//   Debounces the single-bit sensor detection level and counts confirmed
//   detection events, i.e. debounced 0->1 transitions. Each event is offered
//   to a consumer through a valid/ack pair. A sticky alarm is raised once the
//   saturating event count reaches THRESH. A sticky overrun flag records an
//   event that arrived while the previous one was still unacknowledged.
//
// Parameters
//   DEB_CYCLES  consecutive equal samples needed to change o_det (>= 1)
//   CNT_W       width of the event counter
//   THRESH      count at/above which o_alarm sets (< 2**CNT_W)
//
// Ports
//   i_clk      rising-edge clock
//   i_mr_n     asynchronous active-low reset
//   i_z_in     detection level from the sensor stage, synchronous to i_clk
//   i_clr      synchronous clear of o_evt_cnt, o_alarm, o_evt_vld, o_ovr
//   i_evt_ack  consumer acknowledge of o_evt_vld
//   o_det      debounced detection level
//   o_evt_vld  new event pending
//   o_evt_cnt  confirmed events since reset/clear, saturating
//   o_alarm    sticky, o_evt_cnt >= THRESH
//   o_ovr      sticky, event arrived while o_evt_vld was still pending
module sensor_event_monitor #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned THRESH     = 10
) (
  input  logic             i_clk,
  input  logic             i_mr_n,
  input  logic             i_z_in,
  input  logic             i_clr,
  input  logic             i_evt_ack,
  output logic             o_det,
  output logic             o_evt_vld,
  output logic [CNT_W-1:0] o_evt_cnt,
  output logic             o_alarm,
  output logic             o_ovr
);

  // Debounce counter only needs to reach DEB_CYCLES-1 before the decision edge.
  localparam int unsigned DCNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_THR   = CNT_W'(THRESH);
  localparam bit                DEB_ONE   = (DEB_CYCLES == 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RISE_CHK = 2'd1,
    ACTIVE   = 2'd2,
    FALL_CHK = 2'd3
  } state_e;

  state_e            r_state;
  logic [DCNT_W-1:0] r_dcnt;

  logic              w_event;
  logic [CNT_W-1:0]  w_cnt_inc;

  // Event strobe: the edge on which the FSM enters ACTIVE from the rising side.
  always_comb begin
    w_event = 1'b0;
    if (i_z_in) begin
      case (r_state)
        IDLE:     w_event = DEB_ONE;
        RISE_CHK: w_event = (r_dcnt == DCNT_LAST);
        default:  w_event = 1'b0;
      endcase
    end
  end

  // Saturating increment of the event counter.
  always_comb begin
    w_cnt_inc = o_evt_cnt;
    if (o_evt_cnt != CNT_MAX) begin
      w_cnt_inc = o_evt_cnt + 1'b1;
    end
  end

  // Debounce FSM; o_det changes on the edge sampling the DEB_CYCLES-th equal value.
  always_ff @(posedge i_clk or negedge i_mr_n) begin
    if (!i_mr_n) begin
      r_state <= IDLE;
      r_dcnt  <= '0;
      o_det   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_z_in) begin
            if (DEB_ONE) begin
              r_state <= ACTIVE;
              o_det   <= 1'b1;
            end else begin
              r_state <= RISE_CHK;
              r_dcnt  <= DCNT_W'(1);
            end
          end
        end
        RISE_CHK: begin
          if (!i_z_in) begin
            r_state <= IDLE;
            r_dcnt  <= '0;
          end else if (r_dcnt == DCNT_LAST) begin
            r_state <= ACTIVE;
            r_dcnt  <= '0;
            o_det   <= 1'b1;
          end else begin
            r_dcnt  <= r_dcnt + 1'b1;
          end
        end
        ACTIVE: begin
          if (!i_z_in) begin
            if (DEB_ONE) begin
              r_state <= IDLE;
              o_det   <= 1'b0;
            end else begin
              r_state <= FALL_CHK;
              r_dcnt  <= DCNT_W'(1);
            end
          end
        end
        FALL_CHK: begin
          if (i_z_in) begin
            r_state <= ACTIVE;
            r_dcnt  <= '0;
          end else if (r_dcnt == DCNT_LAST) begin
            r_state <= IDLE;
            r_dcnt  <= '0;
            o_det   <= 1'b0;
          end else begin
            r_dcnt  <= r_dcnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_dcnt  <= '0;
          o_det   <= 1'b0;
        end
      endcase
    end
  end

  // Event bookkeeping; clear wins over a same-edge event or acknowledge.
  always_ff @(posedge i_clk or negedge i_mr_n) begin
    if (!i_mr_n) begin
      o_evt_cnt <= '0;
      o_alarm   <= 1'b0;
      o_evt_vld <= 1'b0;
      o_ovr     <= 1'b0;
    end else if (i_clr) begin
      o_evt_cnt <= '0;
      o_alarm   <= 1'b0;
      o_evt_vld <= 1'b0;
      o_ovr     <= 1'b0;
    end else if (w_event) begin
      o_evt_cnt <= w_cnt_inc;
      o_evt_vld <= 1'b1;
      if (w_cnt_inc >= CNT_THR) begin
        o_alarm <= 1'b1;
      end
      // An ack landing on the event edge consumes the old event, so no overrun.
      if (o_evt_vld && !i_evt_ack) begin
        o_ovr <= 1'b1;
      end
    end else if (o_evt_vld && i_evt_ack) begin
      o_evt_vld <= 1'b0;
    end
  end

endmodule
